// File: rtl/gppcu_exec_wb.sv
// GPPCU execute-to-writeback stage: condition evaluation, NZCV flag register and writeback buffer.
// Define GPPCU_EXEC_WB_SKID_EN for a two-entry buffer with a registered oREADY.
module gppcu_exec_wb #(
  parameter int BW   = 32,
  parameter int RW   = 4,
  parameter int CNTW = 16
) (
  input  logic            iCLK,
  input  logic            iRSTn,
  input  logic            iVALID,
  output logic            oREADY,
  input  logic [BW-1:0]   iQ,
  input  logic            iN,
  input  logic            iZ,
  input  logic            iC,
  input  logic            iV,
  input  logic [RW-1:0]   iRD,
  input  logic            iWE,
  input  logic            iFE,
  input  logic [3:0]      iCOND,
  input  logic            iFLUSH,
  output logic            oVALID,
  input  logic            iREADY,
  output logic [BW-1:0]   oQ,
  output logic [RW-1:0]   oRD,
  output logic            oWE,
  output logic [3:0]      oFLAGS,
  output logic            oCARRY,
  output logic [CNTW-1:0] oSQUASH
);

  logic [3:0]      flags;
  logic [CNTW-1:0] squashCount;
  logic            outValid;
  logic [BW-1:0]   outQ;
  logic [RW-1:0]   outRd;
  logic            outWe;
  logic            condPass;
  logic            accept;
  logic            enq;
  logic            pop;
  logic            fN, fZ, fC, fV;

  assign {fN, fZ, fC, fV} = flags;

  always_comb begin
    condPass = 1'b0;
    case (iCOND)
      4'd0:    condPass = fZ;
      4'd1:    condPass = ~fZ;
      4'd2:    condPass = fC;
      4'd3:    condPass = ~fC;
      4'd4:    condPass = fN;
      4'd5:    condPass = ~fN;
      4'd6:    condPass = fV;
      4'd7:    condPass = ~fV;
      4'd8:    condPass = fC & ~fZ;
      4'd9:    condPass = ~fC | fZ;
      4'd10:   condPass = (fN == fV);
      4'd11:   condPass = (fN != fV);
      4'd12:   condPass = ~fZ & (fN == fV);
      4'd13:   condPass = fZ | (fN != fV);
      4'd14:   condPass = 1'b1;
      default: condPass = 1'b0;
    endcase
  end

  // Instructions with neither a register write nor a flag update are dropped at accept.
  assign accept = iVALID & oREADY & ~iFLUSH;
  assign enq    = accept & condPass & (iWE | iFE);
  assign pop    = outValid & iREADY;

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      flags       <= 4'b0000;
      squashCount <= '0;
    end else if (accept) begin
      if (condPass && iFE)
        flags <= {iN, iZ, iC, iV};
      else if (!condPass && squashCount != {CNTW{1'b1}})
        squashCount <= squashCount + 1'b1;
    end
  end

`ifdef GPPCU_EXEC_WB_SKID_EN
  logic          skidValid;
  logic [BW-1:0] skidQ;
  logic [RW-1:0] skidRd;
  logic          skidWe;

  // Skid occupancy is a flop, so iREADY never reaches oREADY combinationally.
  assign oREADY = ~skidValid;

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      outValid  <= 1'b0;
      outQ      <= '0;
      outRd     <= '0;
      outWe     <= 1'b0;
      skidValid <= 1'b0;
      skidQ     <= '0;
      skidRd    <= '0;
      skidWe    <= 1'b0;
    end else if (iFLUSH) begin
      outValid  <= 1'b0;
      skidValid <= 1'b0;
    end else if (!outValid || pop) begin
      if (skidValid) begin
        outValid  <= 1'b1;
        outQ      <= skidQ;
        outRd     <= skidRd;
        outWe     <= skidWe;
        skidValid <= 1'b0;
      end else if (enq) begin
        outValid <= 1'b1;
        outQ     <= iQ;
        outRd    <= iRD;
        outWe    <= iWE;
      end else begin
        outValid <= 1'b0;
      end
    end else if (enq) begin
      skidValid <= 1'b1;
      skidQ     <= iQ;
      skidRd    <= iRD;
      skidWe    <= iWE;
    end
  end
`else
  assign oREADY = ~outValid | iREADY;

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      outValid <= 1'b0;
      outQ     <= '0;
      outRd    <= '0;
      outWe    <= 1'b0;
    end else if (iFLUSH) begin
      outValid <= 1'b0;
    end else if (enq) begin
      outValid <= 1'b1;
      outQ     <= iQ;
      outRd    <= iRD;
      outWe    <= iWE;
    end else if (pop) begin
      outValid <= 1'b0;
    end
  end
`endif

  assign oVALID  = outValid;
  assign oQ      = outQ;
  assign oRD     = outRd;
  assign oWE     = outWe;
  assign oFLAGS  = flags;
  assign oCARRY  = flags[1];
  assign oSQUASH = squashCount;

endmodule

// File: tb/tb_gppcu_exec_wb.sv
// Scoreboard bench for gppcu_exec_wb: driver predicts entries, flags and squash count from the
// condition-code rules; an independent monitor pops and compares whatever the stage presents.
module tb_gppcu_exec_wb;
  localparam int BW   = 32;
  localparam int RW   = 4;
  localparam int CNTW = 16;
`ifdef GPPCU_EXEC_WB_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct packed {
    logic [BW-1:0] q;
    logic [RW-1:0] rd;
    logic          we;
  } entry_t;

  logic            iCLK = 1'b0;
  logic            iRSTn;
  logic            iVALID, iN, iZ, iC, iV, iWE, iFE, iFLUSH, iREADY;
  logic [BW-1:0]   iQ;
  logic [RW-1:0]   iRD;
  logic [3:0]      iCOND;
  logic            oREADY, oVALID, oWE, oCARRY;
  logic [BW-1:0]   oQ;
  logic [RW-1:0]   oRD;
  logic [3:0]      oFLAGS;
  logic [CNTW-1:0] oSQUASH;

  entry_t     sb[$];
  logic [3:0] mFlags;
  int         mSquash;
  bit         running;
  int         tests;
  int         fails;

  gppcu_exec_wb #(.BW(BW), .RW(RW), .CNTW(CNTW)) dut (
    .iCLK(iCLK), .iRSTn(iRSTn), .iVALID(iVALID), .oREADY(oREADY), .iQ(iQ),
    .iN(iN), .iZ(iZ), .iC(iC), .iV(iV), .iRD(iRD), .iWE(iWE), .iFE(iFE),
    .iCOND(iCOND), .iFLUSH(iFLUSH), .oVALID(oVALID), .iREADY(iREADY),
    .oQ(oQ), .oRD(oRD), .oWE(oWE), .oFLAGS(oFLAGS), .oCARRY(oCARRY), .oSQUASH(oSQUASH)
  );

  always #5 iCLK = ~iCLK;

  // Conditions come in complementary pairs: odd codes invert the even code's base test.
  function automatic bit condHolds(input logic [3:0] cond, input logic [3:0] f);
    bit n, z, c, v, base;
    {n, z, c, v} = f;
    case (cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ cond[0];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [BW-1:0] q, input logic [3:0] nzcv,
                               input logic [RW-1:0] rd, input bit we, input bit fe,
                               input logic [3:0] cond, input bit flush, input bit rdy);
    bit expReady, acc, pass;
    @(negedge iCLK);
    iVALID = v; iQ = q; {iN, iZ, iC, iV} = nzcv; iRD = rd;
    iWE = we; iFE = fe; iCOND = cond; iFLUSH = flush; iREADY = rdy;
    #1;
    expReady = SKID ? (sb.size() < 2) : (sb.size() == 0 || rdy);
    checkOutput("oREADY", oREADY, expReady);
    acc  = v && expReady && !flush;
    pass = condHolds(cond, mFlags);
    @(posedge iCLK);
    #1;
    if (flush) begin
      sb.delete();
    end else if (acc) begin
      if (pass) begin
        if (fe) mFlags = nzcv;
        if (we || fe) sb.push_back('{q: q, rd: rd, we: we});
      end else if (mSquash < (1 << CNTW) - 1) begin
        mSquash++;
      end
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, 4'h0, '0, 0, 0, 4'd14, 0, rdy);
  endtask

  task automatic resetPulse();
    @(negedge iCLK);
    iVALID = 0; iREADY = 0; iFLUSH = 0;
    #3 iRSTn = 1'b0;
    #1;
    checkOutput("asyncRst oVALID", oVALID, 0);
    checkOutput("asyncRst oFLAGS", oFLAGS, 0);
    checkOutput("asyncRst oCARRY", oCARRY, 0);
    checkOutput("asyncRst oSQUASH", oSQUASH, 0);
    checkOutput("asyncRst oQ", oQ, 0);
    sb.delete();
    mFlags  = 4'b0000;
    mSquash = 0;
    #2 iRSTn = 1'b1;
  endtask

  // Monitor: compares presented entries against the scoreboard head and pops on handshake.
  always @(negedge iCLK) begin
    #2;
    if (running) begin
      checkOutput("oVALID", oVALID, sb.size() != 0);
      if (oVALID && sb.size() != 0) begin
        checkOutput("oQ", oQ, sb[0].q);
        checkOutput("oRD", oRD, sb[0].rd);
        checkOutput("oWE", oWE, sb[0].we);
        if (iREADY) void'(sb.pop_front());
      end
      checkOutput("oFLAGS", oFLAGS, mFlags);
      checkOutput("oCARRY", oCARRY, mFlags[1]);
      checkOutput("oSQUASH", oSQUASH, mSquash);
    end
  end

  initial begin
    tests = 0; fails = 0; running = 0;
    mFlags = 4'b0000; mSquash = 0;
    iRSTn = 1'b0; iVALID = 0; iQ = '0; {iN, iZ, iC, iV} = 4'h0; iRD = '0;
    iWE = 0; iFE = 0; iCOND = 4'd14; iFLUSH = 0; iREADY = 0;
    repeat (2) @(posedge iCLK);
    #1;
    checkOutput("rst oVALID", oVALID, 0);
    checkOutput("rst oFLAGS", oFLAGS, 0);
    checkOutput("rst oCARRY", oCARRY, 0);
    checkOutput("rst oSQUASH", oSQUASH, 0);
    checkOutput("rst oQ", oQ, 0);
    checkOutput("rst oRD", oRD, 0);
    checkOutput("rst oWE", oWE, 0);
    @(negedge iCLK);
    iRSTn = 1'b1;
    running = 1;

    // ADC producing zero, then EQ passes and NE is squashed.
    applyStimulus(1, 32'h0, 4'b0100, 4'd3, 1, 1, 4'd14, 0, 1);
    applyStimulus(1, 32'h11, 4'b0000, 4'd4, 1, 0, 4'd0, 0, 1);
    applyStimulus(1, 32'h22, 4'b0000, 4'd5, 1, 0, 4'd1, 0, 1);
    idle(2, 1);

    for (int i = 0; i < 8; i++)
      applyStimulus(1, 32'hA000 + i, 4'b0000, i[RW-1:0], 1, 0, 4'd14, 0, 1);
    idle(2, 1);

    // Fill with the consumer stalled; oREADY prediction covers both buffer depths.
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 32'hB000 + i, 4'b0000, 4'd7, 1, 0, 4'd14, 0, 0);
    idle(3, 0);
    idle(3, 1);

    // Flag-only compare sets N, then GE must fail.
    applyStimulus(1, 32'hC0DE, 4'b1000, 4'd1, 0, 1, 4'd14, 0, 1);
    applyStimulus(1, 32'hDEAD, 4'b0001, 4'd2, 1, 1, 4'd10, 0, 1);
    idle(2, 1);

    // Flush with buffered entries and a valid instruction present.
    applyStimulus(1, 32'h1, 4'b0000, 4'd1, 1, 0, 4'd14, 0, 0);
    applyStimulus(1, 32'h2, 4'b0000, 4'd2, 1, 0, 4'd14, 0, 0);
    applyStimulus(1, 32'h3, 4'b1111, 4'd3, 1, 1, 4'd14, 1, 0);
    idle(2, 1);

    // Async reset pulse with entries pending.
    applyStimulus(1, 32'h55, 4'b0010, 4'd9, 1, 1, 4'd14, 0, 0);
    applyStimulus(1, 32'h66, 4'b0000, 4'd8, 1, 0, 4'd14, 0, 0);
    resetPulse();
    idle(3, 1);

    for (int i = 0; i < 1500; i++)
      applyStimulus($urandom_range(0, 9) < 7, $urandom, 4'($urandom_range(0, 15)),
                    RW'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 99) < 3, $urandom_range(0, 9) < 6);
    idle(4, 1);
    running = 0;
    checkOutput("drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
